// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined signed add/subtract unit for the ALU datapath.
//
// The carry chain is cut into STAGES equal slices of WIDTH/STAGES bits.
// Stage k adds slice k using the carry registered by stage k-1. The
// final stage also forms the flags and applies optional saturation
// before loading the output registers.
//
// Handshake: valid-only, no backpressure. An operation is accepted on
// every rising clock edge where enable=1 and in_valid=1. out_valid is
// high for one enabled cycle per completed operation, exactly STAGES
// enabled edges after acceptance. enable=0 freezes every register,
// including the outputs.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   enable     pipeline advance; 0 freezes every register
//   in_valid   op1/op2/mode/saturate are valid this cycle
//   mode       0 = op1+op2, 1 = op1-op2
//   saturate   1 = clamp the result on signed overflow
//   op1, op2   signed operands
//   result     signed result (post-saturation)
//   out_valid  result/flags belong to a completed operation
//   carry      carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow of the raw sum
//   zero       result == 0 (post-saturation)
//   negative   result MSB (post-saturation)
module addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             in_valid,
   input  logic             mode,
   input  logic             saturate,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int S    = WIDTH / STAGES;
   localparam int F    = STAGES - 1;
   localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

   // Inputs seen by each stage. The subtract mode is folded into the
   // effective op2 (inverted) and the slice-0 carry-in, so it does not
   // need to travel further as a separate bit.
   logic [WIDTH-1:0] a_i   [STAGES];
   logic [WIDTH-1:0] b_i   [STAGES];
   logic [WIDTH-1:0] s_i   [STAGES];
   logic             c_i   [STAGES];
   logic             v_i   [STAGES];
   logic             sat_i [STAGES];

   // Partial sum and slice carry produced by each stage
   logic [WIDTH-1:0] s_n [STAGES];
   logic             c_n [STAGES];

   // Registers between stages
   logic [WIDTH-1:0] a_q   [NREG];
   logic [WIDTH-1:0] b_q   [NREG];
   logic [WIDTH-1:0] s_q   [NREG];
   logic             c_q   [NREG];
   logic             v_q   [NREG];
   logic             sat_q [NREG];

   assign a_i[0]   = op1;
   assign b_i[0]   = mode ? ~op2 : op2;
   assign s_i[0]   = '0;
   assign c_i[0]   = mode;
   assign v_i[0]   = in_valid;
   assign sat_i[0] = saturate;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic [S:0]       part;
      logic [WIDTH-1:0] merged;

      assign part = {1'b0, a_i[k][k*S +: S]} + {1'b0, b_i[k][k*S +: S]}
                  + {{S{1'b0}}, c_i[k]};

      // Insert this slice into the partial sum; lower slices come from
      // earlier stages, upper slices are filled in by later stages.
      always_comb begin
         merged            = s_i[k];
         merged[k*S +: S]  = part[S-1:0];
      end

      assign s_n[k] = merged;
      assign c_n[k] = part[S];
   end

   if (STAGES > 1) begin : g_pipe
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < NREG; k++) begin
               a_q[k]   <= '0;
               b_q[k]   <= '0;
               s_q[k]   <= '0;
               c_q[k]   <= 1'b0;
               v_q[k]   <= 1'b0;
               sat_q[k] <= 1'b0;
            end
         end else if (enable) begin
            for (int k = 0; k < NREG; k++) begin
               a_q[k]   <= a_i[k];
               b_q[k]   <= b_i[k];
               s_q[k]   <= s_n[k];
               c_q[k]   <= c_n[k];
               v_q[k]   <= v_i[k];
               sat_q[k] <= sat_i[k];
            end
         end
      end

      for (genvar k = 1; k < STAGES; k++) begin : g_link
         assign a_i[k]   = a_q[k-1];
         assign b_i[k]   = b_q[k-1];
         assign s_i[k]   = s_q[k-1];
         assign c_i[k]   = c_q[k-1];
         assign v_i[k]   = v_q[k-1];
         assign sat_i[k] = sat_q[k-1];
      end
   end

   // Final stage: flags from the raw sum, saturation applied afterwards
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] sat_val;
   logic [WIDTH-1:0] final_res;
   logic             ovf;

   assign raw_sum   = s_n[F];
   assign ovf       = (a_i[F][WIDTH-1] == b_i[F][WIDTH-1])
                   && (raw_sum[WIDTH-1] != a_i[F][WIDTH-1]);
   assign sat_val   = a_i[F][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
   assign final_res = (sat_i[F] && ovf) ? sat_val : raw_sum;

   // Result and flags only load for a completed operation, so bubbles
   // leave the last completed values visible.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result    <= '0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else if (enable) begin
         out_valid <= v_i[F];
         if (v_i[F]) begin
            result   <= final_res;
            carry    <= c_n[F];
            overflow <= ovf;
            zero     <= (final_res == '0);
            negative <= final_res[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Testbench for addsub_pipe. Four instances with different
// (WIDTH, STAGES) share one stimulus stream; each has its own expected
// queue filled when an operation is accepted and drained when the
// instance raises out_valid.
module tb_addsub_pipe;

   localparam int NI = 4;
   localparam int WS [NI] = '{16, 8, 16, 32};
   localparam int SS [NI] = '{2, 1, 4, 8};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        in_valid = 1'b0;
   logic        mode = 1'b0;
   logic        saturate = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;

   // Directed expectations for instance 0 override the model
   logic        use_fix = 1'b0;
   logic [35:0] fix_exp = '0;

   int          errors = 0;
   int          checks = 0;
   int          en_cnt = 0;
   logic        last_en = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!reset && enable) en_cnt <= en_cnt + 1;
      last_en <= !reset && enable;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model on signed integers: {carry, overflow, zero, negative, result}
   function automatic logic [35:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic m,
                                         input logic s);
      longint mask, ua, ub, sa, sb, ssum, maxv, minv, usum, r;
      logic   ovf, cy;
      logic [31:0] rr;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= (longint'(1) << (w-1))) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= (longint'(1) << (w-1))) ? ub - (longint'(1) << w) : ub;
      ssum = m ? sa - sb : sa + sb;
      maxv = (longint'(1) << (w-1)) - 1;
      minv = -(longint'(1) << (w-1));
      ovf  = (ssum > maxv) || (ssum < minv);
      usum = ua + (m ? (~ub & mask) : ub) + longint'(m);
      cy   = ((usum >> w) & 1) != 0;
      r    = ssum;
      if (s && ovf) r = (ssum > maxv) ? maxv : minv;
      rr   = 32'(r & mask);
      return {cy, ovf, (rr == 0), rr[w-1], rr};
   endfunction

   // ---------------- DUT instances + scoreboards ----------------
   for (genvar i = 0; i < NI; i++) begin : g_inst
      localparam int W  = WS[i];
      localparam int ST = SS[i];

      logic [W-1:0] result;
      logic         out_valid, carry, overflow, zero, negative;
      logic [35:0]  exp_q[$];
      int           stamp_q[$];
      logic [36:0]  held = '0;

      addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
         .clock    (clock),
         .reset    (reset),
         .enable   (enable),
         .in_valid (in_valid),
         .mode     (mode),
         .saturate (saturate),
         .op1      (op1[W-1:0]),
         .op2      (op2[W-1:0]),
         .result   (result),
         .out_valid(out_valid),
         .carry    (carry),
         .overflow (overflow),
         .zero     (zero),
         .negative (negative)
      );

      // Push the expectation on the edge that accepts the operation;
      // reset discards everything in flight.
      always @(posedge clock or posedge reset) begin
         if (reset) begin
            exp_q.delete();
            stamp_q.delete();
         end else if (enable && in_valid) begin
            exp_q.push_back((i == 0 && use_fix) ? fix_exp
                                                : model(W, op1, op2, mode, saturate));
            stamp_q.push_back(en_cnt);
         end
      end

      always @(negedge clock) begin
         logic [36:0] now;
         logic [35:0] e;
         int          st;
         now = {out_valid, carry, overflow, zero, negative, 32'(result)};
         if (!reset) begin
            if (!last_en) begin
               check($sformatf("hold[%0d]", i), 64'(now), 64'(held));
            end else if (out_valid) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("spurious_valid[%0d]", i), 64'(out_valid), 64'(0));
               end else begin
                  e  = exp_q.pop_front();
                  st = stamp_q.pop_front();
                  check($sformatf("result_flags[%0d]", i), 64'(now[35:0]), 64'(e));
                  check($sformatf("latency[%0d]", i), 64'(en_cnt - st), 64'(ST));
               end
            end
         end
         held = now;
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic e, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic m, input logic s,
                        input logic uf, input logic [35:0] fe);
      @(negedge clock);
      enable   = e;
      in_valid = v;
      op1      = a;
      op2      = b;
      mode     = m;
      saturate = s;
      use_fix  = uf;
      fix_exp  = fe;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Directed vectors for the 16-bit, 2-stage instance
   // expected = {carry, overflow, zero, negative, result}
   logic [15:0] da [7] = '{16'd5,    16'd3,    16'h00FF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000};
   logic [15:0] db [7] = '{16'd3,    16'd5,    16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
   logic        dm [7] = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
   logic        ds [7] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
   logic [35:0] de [7] = '{{4'b1000, 32'h0002}, {4'b0001, 32'hFFFE}, {4'b0000, 32'h0100},
                           {4'b1010, 32'h0000}, {4'b0101, 32'h8000}, {4'b0100, 32'h7FFF},
                           {4'b1101, 32'h8000}};

   // ---------------- main sequence ----------------
   initial begin
      repeat (2) @(negedge clock);
      #1;
      check("reset_state", {g_inst[0].out_valid, g_inst[0].carry, g_inst[0].overflow,
                            g_inst[0].zero, g_inst[0].negative, 32'(g_inst[0].result)}, '0);
      reset  = 1'b0;
      enable = 1'b1;

      // Directed arithmetic, carry across slices, overflow and saturation
      for (int k = 0; k < 7; k++)
         drive(1'b1, 1'b1, 32'(da[k]), 32'(db[k]), dm[k], ds[k], 1'b1, de[k]);
      idle(10);

      // Back-to-back sweep with a 3-cycle enable drop in the middle
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (a == 8 && b == 0)
               for (int k = 0; k < 3; k++)
                  drive(1'b0, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b0, '0);
            drive(1'b1, 1'b1, 32'(a), 32'(b), 1'((a + b) % 2), 1'b0, 1'b0, '0);
         end
      end
      idle(12);

      // Reset between edges with two operations in flight
      drive(1'b1, 1'b1, 32'h1234, 32'h1111, 1'b0, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b1, 32'h4321, 32'h0101, 1'b1, 1'b0, 1'b0, '0);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("reset_async[0]", {g_inst[0].out_valid, g_inst[0].carry, g_inst[0].overflow,
                               g_inst[0].zero, g_inst[0].negative, 32'(g_inst[0].result)}, '0);
      check("reset_async[3]", {g_inst[3].out_valid, g_inst[3].carry, g_inst[3].overflow,
                               g_inst[3].zero, g_inst[3].negative, 32'(g_inst[3].result)}, '0);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         #1;
         check("no_valid_after_reset", 64'(g_inst[0].out_valid), 64'(0));
      end

      // Random traffic with random bubbles and stalls
      for (int k = 0; k < 400; k++)
         drive(1'($urandom_range(9, 0) != 0), 1'($urandom_range(4, 0) != 0),
               $urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'b0, '0);
      idle(12);

      check("drained[0]", 64'(g_inst[0].exp_q.size()), 64'(0));
      check("drained[1]", 64'(g_inst[1].exp_q.size()), 64'(0));
      check("drained[2]", 64'(g_inst[2].exp_q.size()), 64'(0));
      check("drained[3]", 64'(g_inst[3].exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
